// File: rtl/ps2_keymatrix.sv
// PS/2 set-2 keyboard receiver that keeps a ZX Spectrum 8x5 key matrix image and serves port #FE column data.
// Optional macro PS2_CURSOR_EN maps the arrow keys and backspace to CS+5/8/6/7 and CS+0.
module ps2_keymatrix #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 28000
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] a_hi,
  output logic [4:0] kd_out,
  output logic       magic_key,
  output logic       reset_key,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  // Extra key sources beyond the 40 direct matrix positions (row*5 + col)
  localparam int K_CS_L   = 0;
  localparam int K_SS_L   = 36;
  localparam int K_CS_R   = 40;
  localparam int K_SS_R   = 41;
  localparam int K_ENT_KP = 42;
  localparam int K_ALT_L  = 43;
  localparam int K_ALT_R  = 44;
  localparam int K_DEL    = 45;
  localparam int K_F12    = 46;
  localparam int K_LEFT   = 47;
  localparam int K_RIGHT  = 48;
  localparam int K_DOWN   = 49;
  localparam int K_UP     = 50;
  localparam int K_BKSP   = 51;
  localparam int NKEYS    = 52;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_PARITY = 3'd2,
    S_STOP   = 3'd3,
    S_DECODE = 3'd4
  } state_t;

  logic             clk_meta_r, clk_sync_r, dat_meta_r, dat_sync_r;
  logic             clk_filt_r;
  logic [FW-1:0]    filt_cnt_r;
  logic             fall_s;
  state_t           state_r;
  logic [2:0]       bitcnt_r;
  logic [7:0]       shift_r;
  logic             par_ok_r;
  logic [TW-1:0]    to_cnt_r;
  logic             frame_err_r;
  logic             ext_r, brk_r;
  logic [NKEYS-1:0] keys_r;
  logic [39:0]      matrix_s;
  logic [4:0]       sel_s;
  logic [6:0]       hit_s;
  logic [4:0]       kd_out_r;
  logic             magic_key_r, reset_key_r;

  // Total of data bits plus parity bit must be odd
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Maps {ext, code} to {hit, source index}
  function automatic logic [6:0] key_lookup(input logic [8:0] c);
    logic [6:0] r;
    case (c)
      9'h012: r = {1'b1, 6'd0};   9'h01A: r = {1'b1, 6'd1};   9'h022: r = {1'b1, 6'd2};
      9'h021: r = {1'b1, 6'd3};   9'h02A: r = {1'b1, 6'd4};   9'h01C: r = {1'b1, 6'd5};
      9'h01B: r = {1'b1, 6'd6};   9'h023: r = {1'b1, 6'd7};   9'h02B: r = {1'b1, 6'd8};
      9'h034: r = {1'b1, 6'd9};   9'h015: r = {1'b1, 6'd10};  9'h01D: r = {1'b1, 6'd11};
      9'h024: r = {1'b1, 6'd12};  9'h02D: r = {1'b1, 6'd13};  9'h02C: r = {1'b1, 6'd14};
      9'h016: r = {1'b1, 6'd15};  9'h01E: r = {1'b1, 6'd16};  9'h026: r = {1'b1, 6'd17};
      9'h025: r = {1'b1, 6'd18};  9'h02E: r = {1'b1, 6'd19};  9'h045: r = {1'b1, 6'd20};
      9'h046: r = {1'b1, 6'd21};  9'h03E: r = {1'b1, 6'd22};  9'h03D: r = {1'b1, 6'd23};
      9'h036: r = {1'b1, 6'd24};  9'h04D: r = {1'b1, 6'd25};  9'h044: r = {1'b1, 6'd26};
      9'h043: r = {1'b1, 6'd27};  9'h03C: r = {1'b1, 6'd28};  9'h035: r = {1'b1, 6'd29};
      9'h05A: r = {1'b1, 6'd30};  9'h04B: r = {1'b1, 6'd31};  9'h042: r = {1'b1, 6'd32};
      9'h03B: r = {1'b1, 6'd33};  9'h033: r = {1'b1, 6'd34};  9'h029: r = {1'b1, 6'd35};
      9'h014: r = {1'b1, 6'd36};  9'h03A: r = {1'b1, 6'd37};  9'h031: r = {1'b1, 6'd38};
      9'h032: r = {1'b1, 6'd39};  9'h059: r = {1'b1, 6'd40};  9'h114: r = {1'b1, 6'd41};
      9'h15A: r = {1'b1, 6'd42};  9'h011: r = {1'b1, 6'd43};  9'h111: r = {1'b1, 6'd44};
      9'h171: r = {1'b1, 6'd45};  9'h007: r = {1'b1, 6'd46};
`ifdef PS2_CURSOR_EN
      9'h16B: r = {1'b1, 6'd47};  9'h174: r = {1'b1, 6'd48};  9'h172: r = {1'b1, 6'd49};
      9'h175: r = {1'b1, 6'd50};  9'h166: r = {1'b1, 6'd51};  9'h066: r = {1'b1, 6'd51};
`endif
      default: r = {1'b0, 6'd0};
    endcase
    return r;
  endfunction

  // Two-flop synchronisers; idle bus level is high
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      clk_meta_r <= 1'b1; clk_sync_r <= 1'b1;
      dat_meta_r <= 1'b1; dat_sync_r <= 1'b1;
    end else begin
      clk_meta_r <= ps2_clk; clk_sync_r <= clk_meta_r;
      dat_meta_r <= ps2_dat; dat_sync_r <= dat_meta_r;
    end
  end

  // Glitch filter: a new clock level needs FILTER_LEN consecutive differing samples
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      clk_filt_r <= 1'b1;
      filt_cnt_r <= {FW{1'b0}};
    end else if (clk_sync_r == clk_filt_r) begin
      filt_cnt_r <= {FW{1'b0}};
    end else if (filt_cnt_r == FW'(FILTER_LEN - 1)) begin
      clk_filt_r <= clk_sync_r;
      filt_cnt_r <= {FW{1'b0}};
    end else begin
      filt_cnt_r <= filt_cnt_r + {{(FW-1){1'b0}}, 1'b1};
    end
  end

  assign fall_s = clk_filt_r & ~clk_sync_r & (filt_cnt_r == FW'(FILTER_LEN - 1));

  // Frame receiver with inactivity timeout
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      bitcnt_r    <= 3'd0;
      shift_r     <= 8'h00;
      par_ok_r    <= 1'b0;
      to_cnt_r    <= {TW{1'b0}};
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      if (state_r == S_IDLE || fall_s) to_cnt_r <= {TW{1'b0}};
      else                             to_cnt_r <= to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
      if (state_r != S_IDLE && state_r != S_DECODE && !fall_s && to_cnt_r == TW'(TIMEOUT - 1)) begin
        state_r <= S_IDLE;
      end else begin
        case (state_r)
          S_IDLE: begin
            if (fall_s) begin
              if (!dat_sync_r) begin
                state_r  <= S_DATA;
                bitcnt_r <= 3'd0;
              end else begin
                frame_err_r <= 1'b1;
              end
            end
          end
          S_DATA: begin
            if (fall_s) begin
              shift_r  <= {dat_sync_r, shift_r[7:1]};
              bitcnt_r <= bitcnt_r + 3'd1;
              if (bitcnt_r == 3'd7) state_r <= S_PARITY;
            end
          end
          S_PARITY: begin
            if (fall_s) begin
              par_ok_r <= odd_parity_ok(shift_r, dat_sync_r);
              state_r  <= S_STOP;
            end
          end
          S_STOP: begin
            if (fall_s) begin
              if (dat_sync_r && par_ok_r) begin
                state_r <= S_DECODE;
              end else begin
                frame_err_r <= 1'b1;
                state_r     <= S_IDLE;
              end
            end
          end
          S_DECODE: state_r <= S_IDLE;
          default:  state_r <= S_IDLE;
        endcase
      end
    end
  end

  assign hit_s = key_lookup({ext_r, shift_r});

  // Scancode decoder: prefix flags and per-source key state
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      ext_r  <= 1'b0;
      brk_r  <= 1'b0;
      keys_r <= {NKEYS{1'b0}};
    end else if (frame_err_r) begin
      ext_r <= 1'b0;
      brk_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      case (shift_r)
        8'hE0: ext_r <= 1'b1;
        8'hF0: brk_r <= 1'b1;
        8'hAA, 8'hFC, 8'h00, 8'hFF: begin
          keys_r <= {NKEYS{1'b0}};
          ext_r  <= 1'b0;
          brk_r  <= 1'b0;
        end
        default: begin
          if (hit_s[6]) keys_r[hit_s[5:0]] <= ~brk_r;
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      endcase
    end
  end

  // Fold shared-bit sources into the matrix image and select the addressed rows
  always_comb begin
    matrix_s     = keys_r[39:0];
    matrix_s[0]  = keys_r[K_CS_L] | keys_r[K_CS_R] | keys_r[K_LEFT] | keys_r[K_RIGHT]
                 | keys_r[K_DOWN] | keys_r[K_UP] | keys_r[K_BKSP];
    matrix_s[19] = keys_r[19] | keys_r[K_LEFT];
    matrix_s[20] = keys_r[20] | keys_r[K_BKSP];
    matrix_s[22] = keys_r[22] | keys_r[K_RIGHT];
    matrix_s[23] = keys_r[23] | keys_r[K_UP];
    matrix_s[24] = keys_r[24] | keys_r[K_DOWN];
    matrix_s[30] = keys_r[30] | keys_r[K_ENT_KP];
    matrix_s[36] = keys_r[K_SS_L] | keys_r[K_SS_R];
    sel_s = 5'b00000;
    for (int r = 0; r < 8; r++) begin
      sel_s = sel_s | (matrix_s[r*5 +: 5] & {5{~a_hi[r]}});
    end
  end

  // Registered outputs
  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      kd_out_r    <= 5'b11111;
      magic_key_r <= 1'b0;
      reset_key_r <= 1'b0;
    end else begin
      kd_out_r    <= ~sel_s;
      magic_key_r <= keys_r[K_F12];
      reset_key_r <= (keys_r[K_SS_L] | keys_r[K_SS_R]) & (keys_r[K_ALT_L] | keys_r[K_ALT_R]) & keys_r[K_DEL];
    end
  end

  assign kd_out    = kd_out_r;
  assign magic_key = magic_key_r;
  assign reset_key = reset_key_r;
  assign frame_err = frame_err_r;

endmodule

// File: doc/ps2_keymatrix.md
Name: ps2_keymatrix

Overview:
- Receives PS/2 set-2 scancodes from the keyboard connector (ps2_clk/ps2_dat).
- Keeps a 40-key ZX Spectrum matrix image up to date from those scancodes.
- Returns the active-low column data for the row(s) selected by CPU address A15..A8. This is the kd-equivalent source that the port block reads on port #FE.
- Also produces the magic-button and reset-request levels for the magic and reset logic.

Parameters:
- FILTER_LEN, 8: clk28 cycles that synchronised ps2_clk must be stable before a level change is accepted.
- TIMEOUT, 28000: clk28 cycles without a falling edge (about 1 ms) after which a partial frame is discarded.

Ports:
- clk28  in  1: system clock, 28 MHz.
- rst_n  in  1: synchronous reset, active low.
- ps2_clk  in  1: raw PS/2 clock, asynchronous.
- ps2_dat  in  1: raw PS/2 data, asynchronous.
- a_hi  in  8: CPU address A15..A8; a bit at 0 selects that half-row.
- kd_out  out  5: column data, active low; bit0 is the outermost key of the row.
- magic_key  out  1: level, F12 held.
- reset_key  out  1: level, Ctrl+Alt+Del all held.
- frame_err  out  1: one-cycle pulse on a rejected frame.

Behaviour:
- Clocking and reset: one clock, clk28; reset is synchronous and active-low on rst_n. Reset clears the matrix, the frame state, and the ext/brk flags. Reset outputs: kd_out=5'b11111, magic_key=0, reset_key=0, frame_err=0. Reset asserted mid-frame abandons the frame.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-flop synchroniser.
  - ps2_clk is then filtered: a new level is accepted after FILTER_LEN equal samples.
  - A bit is sampled on an accepted 1->0 transition of the filtered clock.
- Receiver FSM:
  - IDLE: on the first falling edge, data must be 0 (start bit); otherwise frame_err is pulsed and the FSM stays in IDLE. Valid start goes to DATA with bitcnt=0.
  - DATA: shifts 8 bits LSB first, then goes to PARITY.
  - PARITY: the sampled bit must make the odd-parity total correct; go to STOP.
  - STOP: data must be 1. If stop and parity are both good, go to DECODE; otherwise pulse frame_err and go to IDLE.
  - DECODE: one cycle, then IDLE.
  - In any state other than IDLE, TIMEOUT cycles without a falling edge returns the FSM to IDLE. No frame_err pulse and no byte are produced.
- Decoder, one byte per DECODE:
  - E0: set ext.
  - F0: set brk.
  - AA, FC, 00 or FF: clear the whole matrix and both flags.
  - Any other byte: look up {ext, code}. A match sets the key bit (make) or clears it (brk). Then clear ext and brk. An unmapped code only clears the flags.
  - A frame error also clears ext and brk.
- Matrix (internal pressed=1; order is bit0..bit4):
  - A8 row: CS, Z, X, C, V.
  - A9 row: A, S, D, F, G.
  - A10 row: Q, W, E, R, T.
  - A11 row: 1, 2, 3, 4, 5.
  - A12 row: 0, 9, 8, 7, 6.
  - A13 row: P, O, I, U, Y.
  - A14 row: ENTER, L, K, J, H.
  - A15 row: SPACE, SS, M, N, B.
- Scancodes:
  - Standard set-2 letters and digits, e.g. Z=1A, A=1C, Q=15, 1=16, 0=45, P=4D, M=3A, SPACE=29, ENTER=5A.
  - E0 5A (keypad enter) also maps to ENTER.
  - CS: 12 and 59 (left and right shift). SS: 14 and E0 14 (left and right ctrl).
  - Keys sharing a matrix bit are tracked as separate sources and ORed, so releasing one shift while the other is held keeps CS pressed.
- Output:
  - kd_out = ~(OR of all rows whose a_hi bit is 0), registered, 1 clk28 cycle latency from a_hi.
  - a_hi=8'hFF gives 5'b11111.
  - A matrix change is visible on kd_out 1 cycle after DECODE.
- magic_key = 07 held. reset_key = (14 or E0 14) and (11 or E0 11) and E0 71, all held. Both are registered.

Optional Feature:
- Macro PS2_CURSOR_EN.
- Defined: E0 6B, E0 74, E0 72, E0 75 (left, right, down, up arrows) each press CS plus 5, 8, 6, 7 respectively. E0 66 or 66 (backspace) presses CS plus 0. These are held as separate sources ORed into the matrix, as for the shift keys.
- Undefined: those codes are unmapped and ignored, flags clear only.

Test Plan:
- Reset, then a_hi=8'hFE with no keys -> kd_out=5'b11111, magic_key=0, reset_key=0.
- Frame 1A at 12 kHz, then a_hi=8'hFE -> kd_out=5'b11101. Then F0 1A -> 5'b11111.
- Hold 12 and 29, a_hi=8'h7E (A15 and A8 selected) -> kd_out=5'b11110, i.e. CS and SPACE ORed, both bit0.
- Frame with a bad parity bit -> frame_err single-cycle pulse, matrix unchanged. Then a frame aborted after 4 bits and idle for TIMEOUT -> next good frame 16 decodes; a_hi=8'hF7 gives 5'b11110.
- 14, 11, E0 71 -> reset_key=1. E0 F0 71 -> reset_key=0. 07 -> magic_key=1. AA -> matrix cleared, magic_key=0.
- PS2_CURSOR_EN build, E0 75 -> a_hi=8'hFE gives 5'b11110 and a_hi=8'hEF gives 5'b10111. Without the macro, same stimulus -> both 5'b11111.
